// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// dmem_if : load/store request and response bundle between mem stage and dmem
// Revision 1.0
// ============================================================================
interface dmem_if #(
  parameter int XLEN = 32
) ();
  logic            r_v;
  logic            w_v;
  logic [XLEN-1:0] req_adr;
  logic [XLEN-1:0] req_data;
  logic [3:0]      req_strobe;
  logic            hit;
  logic [15:0]     mem_res;
  logic            busy_o;
  logic            err_o;

  modport master (
    output r_v, w_v, req_adr, req_data, req_strobe,
    input  hit, mem_res, busy_o, err_o
  );

  modport slave (
    input  r_v, w_v, req_adr, req_data, req_strobe,
    output hit, mem_res, busy_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : byte-strobed word memory answering loads after LATENCY cycles
// Revision 1.0
// ============================================================================
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  wire   clk,
  input  wire   rst_n,
  dmem_if.slave bus
);

  localparam int         C_AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            w_accept;
  logic            w_rd_sample;

  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  logic [C_AW-1:0] r_rd_idx;
  logic [3:0]      r_rd_strb;
  logic            r_rd_inr;

  logic            r_wbuf_v;
  logic [C_AW-1:0] r_wbuf_idx;
  logic [XLEN-1:0] r_wbuf_data;
  logic [3:0]      r_wbuf_strb;

  logic [15:0]     r_mem_res;
  logic            r_err;

  logic [C_AW-1:0] w_idx;
  logic            w_inr;
  logic            w_busy;
  logic            w_wbuf_commit;
  logic [XLEN-1:0] w_wbuf_word;
  logic            w_wr_direct;
  logic [XLEN-1:0] w_wr_base;
  logic            w_wbuf_load;
  logic [C_AW-1:0] w_rd_idx;
  logic [3:0]      w_rd_strb;
  logic            w_rd_inr;
  logic [XLEN-1:0] w_rd_word;
  logic            w_err_set;
  logic            w_unused_adr;

  function automatic logic [XLEN-1:0] f_merge(input logic [XLEN-1:0] old,
                                              input logic [XLEN-1:0] data,
                                              input logic [3:0]      strb);
    f_merge = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) f_merge[8*i +: 8] = data[8*i +: 8];
    end
  endfunction

  function automatic logic [15:0] f_format(input logic [XLEN-1:0] word,
                                           input logic [3:0]      strb);
    case (strb)
      4'b0001:          f_format = {{8{word[7]}},  word[7:0]};
      4'b0010:          f_format = {{8{word[15]}}, word[15:8]};
      4'b0100:          f_format = {{8{word[23]}}, word[23:16]};
      4'b1000:          f_format = {{8{word[31]}}, word[31:24]};
      4'b0011, 4'b1111: f_format = word[15:0];
      4'b0110:          f_format = word[23:8];
      4'b1100:          f_format = word[31:16];
      default:          f_format = 16'h0000;
    endcase
  endfunction

  function automatic logic f_strb_ok(input logic [3:0] strb);
    case (strb)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b0110, 4'b1100, 4'b1111: f_strb_ok = 1'b1;
      default:                            f_strb_ok = 1'b0;
    endcase
  endfunction

  assign w_idx        = bus.req_adr[C_AW+1:2];
  assign w_inr        = (bus.req_adr >> (C_AW + 2)) == '0;
  assign w_unused_adr = ^bus.req_adr[1:0];
  assign w_busy       = (r_state != S_IDLE);

  // The buffered write lands first; a same-word direct write or read sees it merged.
  assign w_wbuf_commit = r_wbuf_v && !w_busy;
  assign w_wbuf_word   = f_merge(r_mem[r_wbuf_idx], r_wbuf_data, r_wbuf_strb);
  assign w_wr_direct   = rst_n && !w_busy && bus.w_v && !bus.r_v && w_inr;
  assign w_wr_base     = (w_wbuf_commit && (r_wbuf_idx == w_idx)) ? w_wbuf_word : r_mem[w_idx];
  assign w_wbuf_load   = w_busy && bus.w_v && !r_wbuf_v && w_inr;

  assign w_rd_idx  = w_busy ? r_rd_idx  : w_idx;
  assign w_rd_strb = w_busy ? r_rd_strb : bus.req_strobe;
  assign w_rd_inr  = w_busy ? r_rd_inr  : w_inr;
  assign w_rd_word = (w_wbuf_commit && (r_wbuf_idx == w_rd_idx)) ? w_wbuf_word : r_mem[w_rd_idx];

  assign w_err_set = (bus.w_v && !w_inr)
                   | (!w_busy && bus.r_v && bus.w_v)
                   | (w_busy && bus.w_v && r_wbuf_v)
                   | (w_busy && bus.r_v)
                   | (w_accept && (!w_inr || !f_strb_ok(bus.req_strobe)));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_rd_sample = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.r_v) begin
          w_accept  = 1'b1;
          w_cnt_nxt = C_CNT_INIT;
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
            w_rd_sample = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_RESP;
          w_rd_sample = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rd_idx    <= '0;
      r_rd_strb   <= '0;
      r_rd_inr    <= 1'b0;
      r_wbuf_v    <= 1'b0;
      r_wbuf_idx  <= '0;
      r_wbuf_data <= '0;
      r_wbuf_strb <= '0;
      r_mem_res   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_rd_idx  <= w_idx;
        r_rd_strb <= bus.req_strobe;
        r_rd_inr  <= w_inr;
      end
      if (w_wbuf_commit) begin
        r_wbuf_v <= 1'b0;
      end else if (w_wbuf_load) begin
        r_wbuf_v    <= 1'b1;
        r_wbuf_idx  <= w_idx;
        r_wbuf_data <= bus.req_data;
        r_wbuf_strb <= bus.req_strobe;
      end
      if (w_rd_sample) begin
        r_mem_res <= w_rd_inr ? f_format(w_rd_word, w_rd_strb) : 16'h0000;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Array contents survive reset, so this block has no reset branch.
  always_ff @(posedge clk) begin
    if (w_wbuf_commit) begin
      r_mem[r_wbuf_idx] <= w_wbuf_word;
    end
    if (w_wr_direct) begin
      r_mem[w_idx] <= f_merge(w_wr_base, bus.req_data, bus.req_strobe);
    end
  end

  assign bus.hit     = (r_state == S_RESP);
  assign bus.mem_res = r_mem_res;
  assign bus.busy_o  = w_busy;
  assign bus.err_o   = r_err;

endmodule
`default_nettype wire
